// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor (start/busy/done handshake).
// Compile with SERIAL_SUBTRACTOR_ADD_MODE_EN defined to add the mode select.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is sampled only while idle, and A/B (and mode) are captured
  // on that same edge. busy is high while bits are processed. done pulses for one
  // cycle with diff/borrow/overflow valid, and those results hold until the next accept.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             mode;
`endif
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  modport master (
    output start, A, B,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    output mode,
`endif
    input  diff, borrow, overflow, busy, done, dbg_state
  );

  modport slave (
    input  start, A, B,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  mode,
`endif
    output diff, borrow, overflow, busy, done, dbg_state
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor step per clock.
// Optional SERIAL_SUBTRACTOR_ADD_MODE_EN adds a mode bit (1 = subtract, 0 = add).
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             mode_q, mode_d;
`endif

  logic a_bit, b_bit, d_bit, bout, ovf_bit;
  logic sub_bout, add_cout, sub_ovf, add_ovf;

  always_comb begin
    a_bit    = a_sr_q[0];
    b_bit    = b_sr_q[0];
    d_bit    = a_bit ^ b_bit ^ bin_q;
    sub_bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
    add_cout = (a_bit & b_bit) | (bin_q & (a_bit ^ b_bit));
    // Only meaningful on the sign-bit step, where a/b/d are the operand and result MSBs.
    sub_ovf  = (a_bit != b_bit) & (d_bit != a_bit);
    add_ovf  = (a_bit == b_bit) & (d_bit != a_bit);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    bout     = mode_q ? sub_bout : add_cout;
    ovf_bit  = mode_q ? sub_ovf  : add_ovf;
`else
    bout     = sub_bout;
    ovf_bit  = sub_ovf;
`endif
  end

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    r_sr_d     = r_sr_q;
    bin_d      = bin_q;
    count_d    = count_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    mode_d     = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.A;
          b_sr_d  = bus.B;
          r_sr_d  = '0;
          bin_d   = 1'b0;
          count_d = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
          mode_d  = bus.mode;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        r_sr_d  = {d_bit, r_sr_q[WIDTH-1:1]};
        bin_d   = bout;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          diff_d     = {d_bit, r_sr_q[WIDTH-1:1]};
          borrow_d   = bout;
          overflow_d = ovf_bit;
          count_d    = '0;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      r_sr_q     <= '0;
      bin_q      <= 1'b0;
      count_q    <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      mode_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      r_sr_q     <= r_sr_d;
      bin_q      <= bin_d;
      count_q    <= count_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      mode_q     <= mode_d;
`endif
    end
  end

  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.dbg_state = state_q;
endmodule
